stepper_phase_sequencer: RTL and testbench

//  Turns the stepper control flags (run enable, direction, 4-bit speed code) into timed
//  4-phase coil patterns for the motor driver. Ramps the actual speed toward the

---
 rtl/stepper_phase_sequencer.sv | 113 +++++++++++
 tb/tb_stepper_phase_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_phase_sequencer.sv
// stepper_phase_sequencer: ramps run/dir/speed commands into timed 4-phase coil patterns
module stepper_phase_sequencer #(
    parameter int TICK_DIV    = 50000,
    parameter int RAMP_STEPS  = 8,
    parameter bit HOLD_TORQUE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dir,
    input  logic [3:0] speed,
    input  logic       half_step,
    output logic [3:0] phase,
    output logic       step_pulse,
    output logic       moving,
    output logic [3:0] cur_speed,
    output logic       dir_act
);
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
    state_t      state;
    logic [2:0]  idx;
    logic        energised;
    logic [31:0] cnt;
    logic [31:0] step_cnt;
    logic [31:0] interval;
    logic [3:0]  pat;
    logic [2:0]  inc;
    logic        stop_req;
    logic        boundary;
    logic        ramp;

    assign stop_req = !start || speed == 4'd0;
    assign interval = (32'd16 - 32'(cur_speed)) * 32'(TICK_DIV);
    assign boundary = state != IDLE && cnt == interval - 32'd1;
    assign ramp     = boundary && step_cnt == 32'(RAMP_STEPS - 1);
    assign inc      = half_step ? 3'd1 : 3'd2;
    assign moving   = state != IDLE;
    assign phase    = (state != IDLE || (HOLD_TORQUE && energised)) ? pat : 4'b0000;

    always_comb begin
        pat = 4'b1000;
        case (idx)
            3'd0: pat = 4'b1000;
            3'd1: pat = 4'b1100;
            3'd2: pat = 4'b0100;
            3'd3: pat = 4'b0110;
            3'd4: pat = 4'b0010;
            3'd5: pat = 4'b0011;
            3'd6: pat = 4'b0001;
            3'd7: pat = 4'b1001;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 3'd0;
            cur_speed  <= 4'd0;
            dir_act    <= 1'b0;
            energised  <= 1'b0;
            cnt        <= 32'd0;
            step_cnt   <= 32'd0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= boundary;
            if (state == IDLE) begin
                if (!stop_req) begin
                    state     <= RUN;
                    cur_speed <= 4'd1;
                    dir_act   <= dir;
                    cnt       <= 32'd0;
                    step_cnt  <= 32'd0;
                    energised <= 1'b1;
                end
            end else begin
                if (boundary) begin
                    cnt      <= 32'd0;
                    idx      <= dir_act ? idx - inc : idx + inc;
                    step_cnt <= ramp ? 32'd0 : step_cnt + 32'd1;
                end else begin
                    cnt <= cnt + 32'd1;
                end
                if (state == RUN) begin
                    if (stop_req) begin
                        state <= STOP;
                    end else if (ramp) begin
                        // a reversal first brings the motor down to the slowest code
                        if (dir != dir_act) begin
                            if (cur_speed > 4'd1) cur_speed <= cur_speed - 4'd1;
                            else dir_act <= dir;
                        end else if (cur_speed < speed) begin
                            cur_speed <= cur_speed + 4'd1;
                        end else if (cur_speed > speed) begin
                            cur_speed <= cur_speed - 4'd1;
                        end
                    end
                end else begin
                    if (!stop_req) begin
                        state <= RUN;
                    end else if (ramp) begin
                        if (cur_speed > 4'd1) begin
                            cur_speed <= cur_speed - 4'd1;
                        end else begin
                            state     <= IDLE;
                            cur_speed <= 4'd0;
                            cnt       <= 32'd0;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_stepper_phase_sequencer.sv
// tb_stepper_phase_sequencer: directed checks with TICK_DIV=2, RAMP_STEPS=2, HOLD_TORQUE=1
module tb_stepper_phase_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       dir = 1'b0;
    logic [3:0] speed = 4'd0;
    logic       half_step = 1'b1;
    logic [3:0] phase;
    logic       step_pulse;
    logic       moving;
    logic [3:0] cur_speed;
    logic       dir_act;
    int vectors = 0;
    int miscompares = 0;

    stepper_phase_sequencer #(.TICK_DIV(2), .RAMP_STEPS(2), .HOLD_TORQUE(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .speed(speed),
        .half_step(half_step), .phase(phase), .step_pulse(step_pulse),
        .moving(moving), .cur_speed(cur_speed), .dir_act(dir_act)
    );

    always #5 clk = ~clk;

    task automatic wait_step(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!step_pulse && n < 100);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            dir = i[0];
            speed = 4'(i);
            @(posedge clk);
            #1;
            vectors++;
            if (phase !== 4'b0000 || step_pulse !== 1'b0 || moving !== 1'b0 || cur_speed !== 4'd0) begin
                miscompares++;
                $display("FAIL idle_%0d: phase=%b pulse=%b moving=%b cur=%0d, want 0000 0 0 0", i, phase, step_pulse, moving, cur_speed);
            end
        end
    endtask

    task automatic test_accel();
        int exp_int [5] = '{30, 30, 28, 28, 26};
        logic [3:0] exp_ph [5] = '{4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011};
        logic [3:0] exp_cs [5] = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd3};
        int n;
        start = 1'b1; speed = 4'd3; dir = 1'b0; half_step = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (moving !== 1'b1 || cur_speed !== 4'd1 || phase !== 4'b1000) begin
            miscompares++;
            $display("FAIL run_entry: moving=%b cur=%0d phase=%b, want 1 1 1000", moving, cur_speed, phase);
        end
        for (int k = 0; k < 5; k++) begin
            wait_step(n);
            vectors++;
            if (n !== exp_int[k] || phase !== exp_ph[k] || cur_speed !== exp_cs[k]) begin
                miscompares++;
                $display("FAIL accel_step%0d: interval=%0d phase=%b cur=%0d, want %0d %b %0d", k + 1, n, phase, cur_speed, exp_int[k], exp_ph[k], exp_cs[k]);
            end
        end
    endtask

    task automatic test_stop();
        int exp_int [5] = '{26, 28, 28, 30, 30};
        int n;
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_step(n);
            vectors++;
            if (n !== exp_int[k]) begin
                miscompares++;
                $display("FAIL stop_step%0d: interval=%0d, want %0d", k + 1, n, exp_int[k]);
            end
        end
        vectors++;
        if (moving !== 1'b0 || cur_speed !== 4'd0 || phase !== 4'b0100 || dir_act !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_idle: moving=%b cur=%0d phase=%b dir_act=%b, want 0 0 0100 0", moving, cur_speed, phase, dir_act);
        end
        repeat (40) @(posedge clk);
        #1;
        vectors++;
        if (step_pulse !== 1'b0 || phase !== 4'b0100) begin
            miscompares++;
            $display("FAIL hold_torque: pulse=%b phase=%b, want 0 0100", step_pulse, phase);
        end
    endtask

    task automatic test_reverse();
        int exp_int [10] = '{26, 26, 28, 28, 30, 30, 30, 30, 28, 28};
        int n;
        start = 1'b1; speed = 4'd3; dir = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) wait_step(n);
        vectors++;
        if (cur_speed !== 4'd3 || phase !== 4'b0001) begin
            miscompares++;
            $display("FAIL rev_start: cur=%0d phase=%b, want 3 0001", cur_speed, phase);
        end
        dir = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_step(n);
            vectors++;
            if (n !== exp_int[k]) begin
                miscompares++;
                $display("FAIL rev_step%0d: interval=%0d, want %0d", k + 1, n, exp_int[k]);
            end
            if (k == 5) begin
                vectors++;
                if (dir_act !== 1'b1 || cur_speed !== 4'd1 || phase !== 4'b0010) begin
                    miscompares++;
                    $display("FAIL rev_flip: dir_act=%b cur=%0d phase=%b, want 1 1 0010", dir_act, cur_speed, phase);
                end
            end
            if (k == 6) begin
                vectors++;
                if (phase !== 4'b0110) begin
                    miscompares++;
                    $display("FAIL rev_backstep: phase=%b, want 0110", phase);
                end
            end
        end
        vectors++;
        if (cur_speed !== 4'd3 || phase !== 4'b1000 || dir_act !== 1'b1) begin
            miscompares++;
            $display("FAIL rev_reaccel: cur=%0d phase=%b dir_act=%b, want 3 1000 1", cur_speed, phase, dir_act);
        end
        start = 1'b0;
        n = 0;
        while (moving === 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (moving !== 1'b0) begin
            miscompares++;
            $display("FAIL rev_stop: moving=%b after %0d clk, want 0", moving, n);
        end
    endtask

    task automatic test_full_step();
        logic [3:0] fwd [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
        logic [3:0] rev [3] = '{4'b0001, 4'b0010, 4'b0100};
        int n;
        for (int d = 0; d < 2; d++) begin
            do_reset();
            start = 1'b1; speed = 4'd1; dir = d[0]; half_step = 1'b0;
            @(posedge clk);
            #1;
            vectors++;
            if (phase !== 4'b1000 || dir_act !== d[0]) begin
                miscompares++;
                $display("FAIL full_entry_dir%0d: phase=%b dir_act=%b, want 1000 %b", d, phase, dir_act, d[0]);
            end
            for (int k = 0; k < 4 - d; k++) begin
                wait_step(n);
                vectors++;
                if (n !== 30 || phase !== (d == 0 ? fwd[k] : rev[k])) begin
                    miscompares++;
                    $display("FAIL full_dir%0d_step%0d: interval=%0d phase=%b, want 30 %b", d, k + 1, n, phase, d == 0 ? fwd[k] : rev[k]);
                end
            end
            start = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        int n;
        half_step = 1'b1;
        do_reset();
        start = 1'b1; speed = 4'd2; dir = 1'b0;
        @(posedge clk);
        #1;
        wait_step(n);
        wait_step(n);
        repeat (5) @(posedge clk);
        vectors++;
        if (cur_speed !== 4'd2 || phase !== 4'b0100 || moving !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset: cur=%0d phase=%b moving=%b, want 2 0100 1", cur_speed, phase, moving);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (phase !== 4'b0000 || moving !== 1'b0 || step_pulse !== 1'b0 || cur_speed !== 4'd0) begin
            miscompares++;
            $display("FAIL async_reset: phase=%b moving=%b pulse=%b cur=%0d, want 0000 0 0 0", phase, moving, step_pulse, cur_speed);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_accel();
        test_stop();
        test_reverse();
        test_full_step();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
